// File: rtl/datamemory_lanes.sv
// Byte/half/word data memory with sign/zero extension, fault detection and post-reset fill engine.
// Reads register on the falling edge that samples them; o_Busy holds off accesses while filling.
module datamemory_lanes #(
  parameter int NBITS_A = 11,
  parameter int NBITS_D = 32,
  parameter int CELDAS  = 512
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_Init,
  input  logic               i_Rd,
  input  logic               i_Wr,
  input  logic [1:0]         i_Size,
  input  logic               i_Signed,
  input  logic [NBITS_A-1:0] i_Addr,
  input  logic [NBITS_D-1:0] i_InData,
  input  logic [NBITS_A-1:0] i_DbgAddr,
  output logic [NBITS_D-1:0] o_OutData,
  output logic               o_Valid,
  output logic               o_Fault,
  output logic               o_Busy,
  output logic [NBITS_D-1:0] o_DbgData
);

  localparam int NBYTES = NBITS_D / 8;
  localparam int LANEW  = $clog2(NBYTES);
  localparam int IDXW   = $clog2(CELDAS);
  localparam logic [NBITS_A:0] DEPTH = (NBITS_A+1)'(CELDAS);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [NBITS_D-1:0] mem [CELDAS];
  logic [0:0]         state;
  logic [IDXW-1:0]    cnt;

  logic [NBITS_A-1:0] idx;
  logic [LANEW-1:0]   lane;
  logic               aligned, size_ok, in_range, legal, active;
  logic               do_wr, do_rd, do_flt;
  logic [NBYTES-1:0]  be;
  logic [NBITS_D-1:0] wdat, rword, shifted, rdat;

  assign idx  = i_Addr >> LANEW;
  assign lane = i_Addr[LANEW-1:0];

  always_comb begin
    aligned = 1'b1;
    case (i_Size)
      SZ_HALF: aligned = ~i_Addr[0];
      SZ_WORD: aligned = (lane == '0);
      default: aligned = 1'b1;
    endcase
    size_ok  = (i_Size == SZ_BYTE) || (i_Size == SZ_HALF) ||
               ((i_Size == SZ_WORD) && (NBITS_D == 32));
    in_range = ({1'b0, idx} < DEPTH);
    legal    = aligned & size_ok & in_range;
  end

  // Requests only count in IDLE without a concurrent re-init; write beats read.
  assign active = (state == ST_IDLE) & ~i_Init;
  assign do_wr  = active & i_Wr & legal;
  assign do_rd  = active & i_Rd & ~i_Wr & legal;
  assign do_flt = active & (i_Rd | i_Wr) & ~legal;

  always_comb begin
    be   = '0;
    wdat = i_InData;
    for (int b = 0; b < NBYTES; b++) begin
      case (i_Size)
        SZ_BYTE: begin
          be[b]         = (lane == LANEW'(b));
          wdat[8*b +: 8] = i_InData[7:0];
        end
        SZ_HALF: begin
          be[b]         = ((int'(lane) >> 1) == (b >> 1));
          wdat[8*b +: 8] = i_InData[8*(b%2) +: 8];
        end
        default: begin
          be[b]         = 1'b1;
          wdat[8*b +: 8] = i_InData[8*b +: 8];
        end
      endcase
    end
  end

  always_comb begin
    rword   = mem[idx[IDXW-1:0]];
    shifted = rword >> {lane, 3'b000};
    case (i_Size)
      SZ_BYTE: begin
        rdat      = {NBITS_D{i_Signed & shifted[7]}};
        rdat[7:0] = shifted[7:0];
      end
      SZ_HALF: begin
        rdat       = {NBITS_D{i_Signed & shifted[15]}};
        rdat[15:0] = shifted[15:0];
      end
      default: rdat = rword;
    endcase
  end

  always_ff @(negedge i_clk) begin
    if (!i_reset) begin
      state     <= ST_INIT;
      cnt       <= '0;
      o_OutData <= '0;
      o_Valid   <= 1'b0;
      o_Fault   <= 1'b0;
    end else begin
      o_Valid <= do_rd;
      o_Fault <= do_flt;
      if (do_rd)
        o_OutData <= rdat;
      if (state == ST_INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == IDXW'(CELDAS - 1))
          state <= ST_IDLE;
      end else if (i_Init) begin
        state <= ST_INIT;
        cnt   <= '0;
      end
    end
  end

  // Reset low suppresses every memory write, including a fill step or a store in flight.
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      if (state == ST_INIT) begin
        mem[cnt] <= NBITS_D'(cnt);
      end else if (do_wr) begin
        for (int b = 0; b < NBYTES; b++)
          if (be[b])
            mem[idx[IDXW-1:0]][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  assign o_Busy    = (state == ST_INIT);
  assign o_DbgData = ({1'b0, i_DbgAddr} < DEPTH) ? mem[i_DbgAddr[IDXW-1:0]] : '0;

endmodule

// File: tb/tb_datamemory_lanes.sv
// Directed bench for datamemory_lanes: fill timing, lane stores, extension, faults, re-init.
module tb_datamemory_lanes;
  localparam int NA = 12;
  localparam int ND = 32;
  localparam int NC = 512;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_Init = 1'b0;
  logic          i_Rd = 1'b0;
  logic          i_Wr = 1'b0;
  logic [1:0]    i_Size = 2'b00;
  logic          i_Signed = 1'b0;
  logic [NA-1:0] i_Addr = '0;
  logic [ND-1:0] i_InData = '0;
  logic [NA-1:0] i_DbgAddr = '0;
  logic [ND-1:0] o_OutData;
  logic          o_Valid;
  logic          o_Fault;
  logic          o_Busy;
  logic [ND-1:0] o_DbgData;

  int checks = 0;
  int errors = 0;
  int n;

  datamemory_lanes #(.NBITS_A(NA), .NBITS_D(ND), .CELDAS(NC)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_Init(i_Init), .i_Rd(i_Rd), .i_Wr(i_Wr),
    .i_Size(i_Size), .i_Signed(i_Signed), .i_Addr(i_Addr), .i_InData(i_InData),
    .i_DbgAddr(i_DbgAddr), .o_OutData(o_OutData), .o_Valid(o_Valid),
    .o_Fault(o_Fault), .o_Busy(o_Busy), .o_DbgData(o_DbgData)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive at the rising edge, let the falling edge sample, then look #1 later.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [NA-1:0] a, input logic [31:0] d);
    @(posedge i_clk);
    i_Rd = rd; i_Wr = wr; i_Size = sz; i_Signed = sg; i_Addr = a; i_InData = d;
    @(negedge i_clk);
    #1;
    i_Rd = 1'b0; i_Wr = 1'b0;
  endtask

  task automatic dbg(input string tag, input logic [NA-1:0] a, input logic [31:0] exp);
    i_DbgAddr = a;
    #1;
    chk(tag, o_DbgData, exp);
  endtask

  task automatic wait_busy_low();
    n = 0;
    while (o_Busy && n < 2000) begin
      @(negedge i_clk);
      #1;
      n++;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_out", o_OutData, 32'h0);
    chk("rst_vld", {31'b0, o_Valid}, 32'h0);
    chk("rst_flt", {31'b0, o_Fault}, 32'h0);
    chk("rst_busy", {31'b0, o_Busy}, 32'h1);

    // Fill takes exactly CELDAS falling edges
    @(posedge i_clk);
    i_reset = 1'b1;
    wait_busy_low();
    chk("init_cycles", n, NC);
    dbg("dbg_7", 12'd7, 32'h7);
    dbg("dbg_511", 12'd511, 32'd511);
    dbg("dbg_oor", 12'd600, 32'h0);

    // Word store then sub-word reads
    access(0, 1, 2'b10, 0, 12'h010, 32'h80FF7F01);
    chk("wr_vld", {31'b0, o_Valid}, 32'h0);
    chk("wr_flt", {31'b0, o_Fault}, 32'h0);
    dbg("wr_word", 12'd4, 32'h80FF7F01);
    access(1, 0, 2'b00, 1, 12'h011, 32'h0);
    chk("rb11_dat", o_OutData, 32'h0000007F);
    chk("rb11_vld", {31'b0, o_Valid}, 32'h1);
    @(negedge i_clk);
    #1;
    chk("vld_pulse", {31'b0, o_Valid}, 32'h0);
    access(1, 0, 2'b00, 1, 12'h012, 32'h0);
    chk("rb12_s", o_OutData, 32'hFFFFFFFF);
    access(1, 0, 2'b01, 0, 12'h012, 32'h0);
    chk("rh12_u", o_OutData, 32'h000080FF);

    // Byte store only touches lane 3
    access(0, 1, 2'b00, 0, 12'h013, 32'h123456AA);
    dbg("sb13", 12'd4, 32'hAAFF7F01);
    access(1, 0, 2'b10, 0, 12'h010, 32'h0);
    chk("rw10", o_OutData, 32'hAAFF7F01);

    // Faults: memory and o_OutData untouched, no valid
    access(1, 0, 2'b01, 0, 12'h005, 32'h0);
    chk("f_half_flt", {31'b0, o_Fault}, 32'h1);
    chk("f_half_vld", {31'b0, o_Valid}, 32'h0);
    chk("f_half_out", o_OutData, 32'hAAFF7F01);
    access(1, 0, 2'b10, 0, 12'h002, 32'h0);
    chk("f_word_flt", {31'b0, o_Fault}, 32'h1);
    chk("f_word_out", o_OutData, 32'hAAFF7F01);
    access(0, 1, 2'b00, 0, 12'h800, 32'h55);
    chk("f_range_flt", {31'b0, o_Fault}, 32'h1);
    dbg("f_range_mem0", 12'd0, 32'h0);
    access(1, 0, 2'b11, 0, 12'h010, 32'h0);
    chk("f_rsv_flt", {31'b0, o_Fault}, 32'h1);
    chk("f_rsv_vld", {31'b0, o_Valid}, 32'h0);
    access(0, 1, 2'b01, 0, 12'h011, 32'hFFFF);
    chk("f_wmis_flt", {31'b0, o_Fault}, 32'h1);
    dbg("f_wmis_mem", 12'd4, 32'hAAFF7F01);
    @(negedge i_clk);
    #1;
    chk("flt_pulse", {31'b0, o_Fault}, 32'h0);

    // Read+write together: write wins
    access(1, 1, 2'b10, 0, 12'h020, 32'h12345678);
    chk("rw_vld", {31'b0, o_Valid}, 32'h0);
    chk("rw_out", o_OutData, 32'hAAFF7F01);
    dbg("rw_mem", 12'd8, 32'h12345678);
    access(1, 0, 2'b10, 0, 12'h020, 32'h0);
    chk("rw_rd", o_OutData, 32'h12345678);
    access(0, 1, 2'b01, 0, 12'h022, 32'h0000BEEF);
    dbg("sh22", 12'd8, 32'hBEEF5678);
    access(1, 0, 2'b00, 0, 12'h023, 32'h0);
    chk("rb23_u", o_OutData, 32'h000000BE);
    access(1, 0, 2'b01, 1, 12'h022, 32'h0);
    chk("rh22_s", o_OutData, 32'hFFFFBEEF);

    // Reset in the middle of a fill restarts the count
    @(posedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    #1;
    chk("rst2_out", o_OutData, 32'h0);
    chk("rst2_busy", {31'b0, o_Busy}, 32'h1);
    @(posedge i_clk);
    i_reset = 1'b1;
    repeat (100) @(negedge i_clk);
    #1;
    dbg("mid_init_8", 12'd8, 32'h8);
    @(posedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    @(posedge i_clk);
    i_reset = 1'b1;
    wait_busy_low();
    chk("reinit_cycles", n, NC);

    // Re-init from IDLE; accesses in that cycle and during the fill are ignored
    access(0, 1, 2'b10, 0, 12'h010, 32'hDEADBEEF);
    dbg("pre_init", 12'd4, 32'hDEADBEEF);
    @(posedge i_clk);
    i_Init = 1'b1; i_Wr = 1'b1; i_Size = 2'b10; i_Addr = 12'h030; i_InData = 32'hFFFFFFFF;
    @(negedge i_clk);
    #1;
    i_Init = 1'b0; i_Wr = 1'b0;
    chk("init_busy", {31'b0, o_Busy}, 32'h1);
    chk("init_flt0", {31'b0, o_Fault}, 32'h0);
    access(0, 1, 2'b10, 0, 12'h040, 32'hCAFEBABE);
    chk("busy_wr_flt", {31'b0, o_Fault}, 32'h0);
    access(1, 0, 2'b10, 0, 12'h010, 32'h0);
    chk("busy_rd_vld", {31'b0, o_Valid}, 32'h0);
    wait_busy_low();
    chk("iinit_cycles", n + 2, NC);
    dbg("restore_4", 12'd4, 32'h4);
    dbg("restore_8", 12'd8, 32'h8);
    dbg("restore_12", 12'd12, 32'hC);
    dbg("restore_16", 12'd16, 32'h10);
    dbg("restore_511", 12'd511, 32'd511);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/datamemory_lanes.md
# datamemory_lanes

Parametrised data memory for the MIPS datapath's memory stage, successor to the fixed 16-bit, 10-cell data memory. It adds byte/halfword/word access with sign or zero extension, a byte-addressed interface with alignment and range checking, a registered read with a valid strobe, and a sequential initialisation engine that fills memory after reset. A combinational debug read port lets the debug unit dump memory contents.

## Interface
- NBITS_A, 11: byte-address width.
- NBITS_D, 32: word width; legal values are 16 and 32.
- CELDAS, 512: depth in words; must not exceed 2^NBITS_A / (NBITS_D/8).
- i_clk, in, 1: clock; all state updates occur on the falling edge.
- i_reset, in, 1: synchronous, active-low reset, sampled on the falling edge of i_clk.
- i_Init, in, 1: one-cycle request to re-run initialisation.
- i_Rd, in, 1: read request.
- i_Wr, in, 1: write request.
- i_Size, in, 2: access size; 00 = byte, 01 = half, 10 = word, 11 = reserved.
- i_Signed, in, 1: on reads, 1 = sign-extend, 0 = zero-extend.
- i_Addr, in, NBITS_A: byte address.
- i_InData, in, NBITS_D: write data; the low bytes are used for sub-word stores.
- i_DbgAddr, in, NBITS_A: debug word index, i.e. a word address, not a byte address.
- o_OutData, out, NBITS_D: registered read data.
- o_Valid, out, 1: one-cycle strobe indicating o_OutData was updated.
- o_Fault, out, 1: one-cycle strobe for a misaligned, out-of-range or reserved-size access.
- o_Busy, out, 1: initialisation in progress.
- o_DbgData, out, NBITS_D: combinational read of word i_DbgAddr; reads 0 if the index is out of range.

## Operation
- Word index = i_Addr >> log2(NBITS_D/8). Byte lane = i_Addr[1:0] for 32-bit words, i_Addr[0] for 16-bit words. Byte order is little-endian.
- State machine has two states, INIT and IDLE.
- Reset (i_reset = 0):
  - State goes to INIT and the init counter goes to 0.
  - o_OutData = 0, o_Valid = 0, o_Fault = 0, o_Busy = 1.
- INIT:
  - Each falling edge writes memory[cnt] = cnt (zero-extended) and increments cnt.
  - After writing CELDAS-1, the state moves to IDLE and o_Busy falls on that same edge.
  - i_Rd, i_Wr and i_Init are ignored. o_Valid and o_Fault stay 0.
- IDLE with i_Init = 1: state goes to INIT and cnt goes to 0. Any i_Rd or i_Wr in the same cycle is ignored.
- An access is legal only if all of the following hold:
  - Size is aligned: a half requires i_Addr[0] = 0; a word requires i_Addr[1:0] = 0.
  - Word index < CELDAS.
  - i_Size ≠ 11, and i_Size = 10 is not used when NBITS_D = 16.
- Illegal access: o_Fault pulses, memory is unchanged, and o_OutData holds its value.
- Write (i_Wr = 1, legal): only the addressed lanes are updated; all other lanes are preserved.
- Read (i_Rd = 1, legal):
  - The addressed byte or half is extracted.
  - It is sign- or zero-extended per i_Signed.
  - o_OutData is loaded and o_Valid pulses.
- i_Rd and i_Wr both high: the write wins, the read is dropped and o_Valid stays 0.
- No request: o_OutData holds its value.
- o_DbgData is available in both states; during INIT it may show partially initialised contents.

## Timing
- Initialisation takes exactly CELDAS falling edges after reset deassertion. For example, with CELDAS = 512, o_Busy is high for 512 cycles.
- Reset asserted mid-INIT restarts the counter at 0.
- Reset asserted mid-access aborts the access: no write occurs and outputs take their reset values.
- Read latency: a request sampled at falling edge T yields o_OutData and o_Valid = 1 from edge T until edge T+1.
- Write to edge T: a read sampled at T+1 of the same address returns the new data.
- o_Valid and o_Fault are strictly single-cycle and are never both high.
- o_DbgData reflects a write one combinational delay after the writing edge.

## Test plan
- Reset, then count cycles until o_Busy falls → exactly CELDAS cycles; o_DbgData for index 7 = 0x00000007.
- Word write 0x80FF7F01 at address 0x10, then read byte at 0x11 with i_Signed = 1 → 0x0000007F, o_Valid = 1.
  - Byte read at 0x12 with i_Signed = 1 → 0xFFFFFFFF.
  - Half read at 0x12 with i_Signed = 0 → 0x000080FF.
- Byte store 0xAA to 0x13 after the previous write → word 0x10 = 0xAAFF7F01; other lanes unchanged.
- Half read at 0x05, word read at 0x02, index ≥ CELDAS, and i_Size = 11 → each gives an o_Fault pulse, no o_Valid, and memory plus o_OutData unchanged.
- i_Rd and i_Wr both high at 0x20 with data 0x12345678 → memory is written and o_Valid = 0; the next read returns 0x12345678.
- Assert reset at init cycle 100, then re-run i_Init from IDLE → o_Busy rises; Rd/Wr issued during INIT are ignored and all contents are restored to the k pattern.
